fifo_read_stage: RTL and testbench
==================================

Name: fifo_read_stage

Overview:
- Read-side consumer of the FIFO pointer controller.
- Turns the controller's empty/take interface and a synchronous-read FIFO memory into a registered valid/ready output stream.
- Prefetches up to two words into an internal 2-entry output buffer. This hides the one-cycle memory read latency and sustains one word per cycle.
- Sits between the FIFO controller plus memory and any downstream consumer.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word.
- FIFO_ASIZE, 4, FIFO address width; must match the controller's address width.

Ports:
- in_clock  input  1  clock; all state updates on the rising edge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_empty  input  1  FIFO empty flag from the controller.
- out_take  output  1  pop request to the controller; advances its read pointer.
- in_read_pointer  input  FIFO_ASIZE  current read pointer from the controller.
- out_mem_addr  output  FIFO_ASIZE  read address to the FIFO memory.
- in_mem_data  input  DATA_WIDTH  memory read data, valid one cycle after the address.
- out_valid  output  1  out_data holds a valid word.
- in_ready  input  1  consumer accepts the word this cycle.
- out_data  output  DATA_WIDTH  head word of the output buffer.
- out_count  output  2  number of words held in the output buffer (0..2).

Behaviour:
- Reset (in_reset_n=0, async, takes effect immediately):
  - out_count=0, out_valid=0, out_data=0.
  - pending flag=0; buffer entries cleared.
  - out_take=0 while reset is held.
- Reset mid-operation discards buffered and in-flight words. The controller must be reset in the same window; the integrator guarantees this.
- out_mem_addr = in_read_pointer (combinational). The memory registers the address, so data for the address presented in cycle N appears on in_mem_data in cycle N+1.
- pop = out_valid && in_ready.
- Credit rule: out_take = in_reset_n && !in_empty && (out_count + pending - pop) < 2.
  - out_take never asserts while in_empty=1, so the controller only sees take in its normal or full cases.
  - out_take has a combinational path from in_ready and in_empty. This is accepted; downstream must not loop in_ready back from out_take.
- Pending flag: pending <= out_take.
- Buffer write: when pending=1, in_mem_data is written into the buffer tail this cycle.
- Buffer is a 2-entry FIFO (head/tail registers). out_data is the head register; out_valid = (out_count != 0), both registered.
- Per-cycle buffer update:
  - write only: count+1; the word goes to head if count was 0, else to tail.
  - pop only: count-1; tail shifts into head.
  - write and pop with count=1: head is replaced by the new word; count stays 1.
  - write and pop with count=2: tail moves to head, new word goes to tail; count stays 2.
- The credit rule guarantees a write never occurs with count=2 and no pop. Overflow is impossible; a bench assertion checks it.
- Stability: while out_valid=1 and in_ready=0, out_data and out_valid hold.
- No bypass: a word written in cycle N is visible on out_data in cycle N+1.
- Latency: in_empty falls in cycle 0 → out_take=1 in cycle 0 → pending in cycle 1 → out_valid=1 in cycle 2.
- Throughput: one word per cycle sustained when in_ready=1 and the FIFO is non-empty.
- A single word in the FIFO produces exactly one take: after the take the controller reports empty.
- A controller take-with-put on the empty state does not arise, because out_take is gated by !in_empty.

Test Plan:
- Reset: assert in_reset_n=0 mid-stream with out_count=2 → out_valid=0, out_count=0, out_data=0 immediately; after release, no out_take until in_empty=0.
- Single word: FIFO holds 0xA5, in_ready=1 → out_take high for exactly 1 cycle; out_valid=1 with out_data=0xA5 two cycles after in_empty falls; valid for 1 cycle.
- Streaming: FIFO preloaded with 0x01..0x10 (16 words), in_ready=1 → after 2-cycle latency, words appear in order with out_valid continuous for 16 cycles; out_take asserts 16 times total.
- Backpressure: preload 0x01..0x05, hold in_ready=0 → exactly 2 takes, out_count=2, out_data=0x01 stable; release in_ready → 0x01..0x05 delivered in order, no loss or duplication.
- Random ready: 200 words, in_ready randomly toggled at 50% → output sequence equals input sequence; out_count never exceeds 2; out_take never asserted while in_empty=1.
- Boundary: FIFO goes empty while in_ready=1 and count=1 → last word delivered, then out_valid=0; a new word arriving next cycle resumes output with 2-cycle latency.

Source files
------------

// File: rtl/fifo_read_stage.sv
// Read-side stage of a FIFO: issues takes to the pointer controller, absorbs the
// one-cycle memory read latency in a 2-entry buffer and presents a valid/ready stream.
module fifo_read_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_ASIZE = 4
) (
  input  logic                  in_clock,
  input  logic                  in_reset_n,
  input  logic                  in_empty,
  output logic                  out_take,
  input  logic [FIFO_ASIZE-1:0] in_read_pointer,
  output logic [FIFO_ASIZE-1:0] out_mem_addr,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_count
);

  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  pending_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;
  logic                  write;
  logic [2:0]            occupancy;

  assign out_mem_addr = in_read_pointer;
  assign pop          = valid_q && in_ready;
  assign write        = pending_q;

  // Words already held plus the one in flight, minus the one leaving now;
  // a take is only issued if its word is guaranteed a free slot next cycle.
  assign occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
  assign out_take  = in_reset_n && !in_empty && (occupancy < 3'd2);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves count_d unassigned (no latch).
    count_d = count_q;
    case ({write, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: head/tail are only two words, so they are reset like any other register
  // to give out_data a defined zero; larger storage arrays would be left unreset.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      count_q   <= 2'd0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pending_q <= out_take;
      count_q   <= count_d;
      valid_q   <= (count_d != 2'd0);
      case ({write, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_mem_data;
          else                 tail_q <= in_mem_data;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= in_mem_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_mem_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_fifo_read_stage.sv
// Bench for fifo_read_stage: models the pointer controller and synchronous memory as a
// plain circular array, scoreboards every delivered word against the written sequence.
module tb_fifo_read_stage;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_empty;
  logic          out_take;
  logic [AW-1:0] in_read_pointer;
  logic [AW-1:0] out_mem_addr;
  logic [DW-1:0] in_mem_data = '0;
  logic          out_valid;
  logic          in_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_count;

  fifo_read_stage #(.DATA_WIDTH(DW), .FIFO_ASIZE(AW)) dut (
    .in_clock       (clk),
    .in_reset_n     (rst_n),
    .in_empty       (in_empty),
    .out_take       (out_take),
    .in_read_pointer(in_read_pointer),
    .out_mem_addr   (out_mem_addr),
    .in_mem_data    (in_mem_data),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_count      (out_count)
  );

  always #5 clk = ~clk;

  // Controller + memory model: a circular array with wrap-bit pointers.
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr = '0;
  logic [AW:0]   rptr;
  logic [AW:0]   fill;
  assign in_empty        = (wptr == rptr);
  assign fill            = wptr - rptr;
  assign in_read_pointer = rptr[AW-1:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rptr <= '0;
    else if (out_take) rptr <= rptr + 1'b1;
  end

  always @(posedge clk) in_mem_data <= mem[out_mem_addr];

  int tests = 0;
  int fails = 0;
  int take_total = 0;
  int valid_cycles = 0;
  int viol = 0;
  logic take_seen;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) take_seen <= 1'b0;
    else begin
      take_seen <= out_take;
      if (out_take) take_total <= take_total + 1;
    end
  end

  // Monitor: sampled on the falling edge, half a cycle from any state change.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_count > 2'd2) viol++;
      if (out_take && in_empty) viol++;
      if (out_valid != (out_count != 2'd0)) viol++;
      if (take_seen && out_count == 2'd2 && !(out_valid && in_ready)) viol++;
      if (out_valid) valid_cycles++;
      if (out_valid && in_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
        else check("word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wptr[AW-1:0]] = w;
    wptr = wptr + 1'b1;
    exp_q.push_back(w);
  endtask

  task automatic drain(input string name, input int budget);
    bit done = 0;
    in_ready = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && !out_valid && in_empty) done = 1;
      else step();
    end
    check(name, exp_q.size(), 0);
  endtask

  int t0, v0;
  int written;

  initial begin
    // Power-up reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_data", out_data, 0);
    check("rst_take", out_take, 0);
    rst_n = 1'b1;
    t0 = take_total;
    repeat (4) step();
    check("idle_no_take", take_total - t0, 0);

    // Single word, ready high.
    in_ready = 1'b1;
    t0 = take_total;
    v0 = valid_cycles;
    push_word(8'hA5);
    #1;
    check("single_take_now", out_take, 1);
    step();
    check("single_valid_c1", out_valid, 0);
    step();
    check("single_valid_c2", out_valid, 1);
    check("single_data_c2", out_data, 8'hA5);
    step();
    check("single_valid_c3", out_valid, 0);
    repeat (3) step();
    check("single_takes", take_total - t0, 1);
    check("single_valid_len", valid_cycles - v0, 1);

    // Streaming 16 preloaded words.
    t0 = take_total;
    v0 = valid_cycles;
    for (int i = 1; i <= 16; i++) push_word(DW'(i));
    step();
    step();
    check("stream_first_valid", out_valid, 1);
    check("stream_first_data", out_data, 8'h01);
    repeat (20) step();
    check("stream_takes", take_total - t0, 16);
    check("stream_valid_len", valid_cycles - v0, 16);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure.
    in_ready = 1'b0;
    t0 = take_total;
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    repeat (6) step();
    check("bp_takes", take_total - t0, 2);
    check("bp_count", out_count, 2);
    check("bp_data", out_data, 8'h01);
    repeat (4) step();
    check("bp_data_stable", out_data, 8'h01);
    check("bp_valid_stable", out_valid, 1);
    drain("bp_drain", 40);
    check("bp_takes_total", take_total - t0, 5);

    // Boundary: empty at count=1, then a new word resumes with 2-cycle latency.
    push_word(8'h3C);
    step();
    step();
    check("bnd_valid_a", out_valid, 1);
    check("bnd_count_a", out_count, 1);
    step();
    check("bnd_gone", out_valid, 0);
    push_word(8'hC3);
    step();
    check("bnd_lat_c1", out_valid, 0);
    step();
    check("bnd_lat_c2", out_valid, 1);
    check("bnd_data_b", out_data, 8'hC3);
    drain("bnd_drain", 20);

    // Random ready, 200 words.
    written = 0;
    while (written < 200) begin
      in_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0 && fill < (AW+1)'(DEPTH)) begin
        push_word(DW'($urandom));
        written++;
      end
      step();
    end
    drain("rand_drain", 2000);
    check("rand_invariants", viol, 0);

    // Reset mid-stream with count=2.
    in_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(8'h50 + i));
    repeat (5) step();
    check("mid_count_before", out_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_take", out_take, 0);
    exp_q.delete();
    wptr = '0;
    step();
    rst_n = 1'b1;
    t0 = take_total;
    repeat (4) step();
    check("mid_no_take_empty", take_total - t0, 0);
    check("mid_valid_after", out_valid, 0);
    push_word(8'h77);
    drain("mid_resume", 20);
    check("mid_resume_takes", take_total - t0, 1);
    check("final_invariants", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
